// File: rtl/wide_add_sequencer.sv
// Computes WIDTH-bit sums one 4-bit nibble at a time, LSB first, through an external
// pipelined 4-bit adder. Each nibble's carry-out becomes the next nibble's carry-in.
module wide_add_sequencer #(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int CNTW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(ADD_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    // Operand registers hold the nibbles not yet issued; they shift down by one nibble per
    // issue so the next nibble is always at [3:0]. add_cin itself carries the chain.
    // NOTE: non-blocking assignments throughout, so every read below sees the pre-edge value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            busy      <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= in_a >> 4;
                        b_reg    <= in_b >> 4;
                        idx      <= '0;
                        out_sum  <= '0;
                        out_cout <= 1'b0;
                        add_a    <= in_a[3:0];
                        add_b    <= in_b[3:0];
                        add_cin  <= in_cin;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt     <= CNT_INIT;
                    add_a   <= '0;
                    add_b   <= '0;
                    add_cin <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNTW'(1);
                    end else begin
                        out_sum[4*idx +: 4] <= add_sum;
                        if (idx == LAST_IDX) begin
                            out_cout  <= add_cout;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx     <= idx + IDXW'(1);
                            add_a   <= a_reg[3:0];
                            add_b   <= b_reg[3:0];
                            add_cin <= add_cout;
                            a_reg   <= a_reg >> 4;
                            b_reg   <= b_reg >> 4;
                            state   <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Two sequencer instances (16-bit/lat 2 directed, 8-bit/lat 3 random), each driving a
// behavioural pipelined 4-bit adder; results are scored against plain A+B+cin.
module tb_wide_add_sequencer;

    localparam int LAT16     = 2;
    localparam int LAT8      = 3;
    localparam int EXP_LAT16 = 4 * (LAT16 + 1) + 1;
    localparam int EXP_LAT8  = 2 * (LAT8 + 1) + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 16-bit instance signals
    logic        in_valid16 = 1'b0, in_ready16, in_cin16 = 1'b0;
    logic [15:0] in_a16 = '0, in_b16 = '0, out_sum16;
    logic        out_valid16, out_ready16 = 1'b1, out_cout16, busy16;
    logic [3:0]  add_a16, add_b16, add_sum16;
    logic        add_cin16, add_cout16;

    // 8-bit instance signals
    logic        in_valid8 = 1'b0, in_ready8, in_cin8 = 1'b0;
    logic [7:0]  in_a8 = '0, in_b8 = '0, out_sum8;
    logic        out_valid8, out_ready8 = 1'b1, out_cout8, busy8;
    logic [3:0]  add_a8, add_b8, add_sum8;
    logic        add_cin8, add_cout8;

    wide_add_sequencer #(.WIDTH(16), .ADD_LAT(LAT16)) dut16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .in_a(in_a16), .in_b(in_b16), .in_cin(in_cin16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_sum(out_sum16), .out_cout(out_cout16), .busy(busy16),
        .add_a(add_a16), .add_b(add_b16), .add_cin(add_cin16),
        .add_sum(add_sum16), .add_cout(add_cout16)
    );

    wide_add_sequencer #(.WIDTH(8), .ADD_LAT(LAT8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_cin(in_cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_sum(out_sum8), .out_cout(out_cout8), .busy(busy8),
        .add_a(add_a8), .add_b(add_b8), .add_cin(add_cin8),
        .add_sum(add_sum8), .add_cout(add_cout8)
    );

    // Pipelined 4-bit adders: result of the inputs present at an edge appears LAT edges later.
    logic [4:0] p16 [LAT16];
    logic [4:0] p8  [LAT8];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT16; i++) p16[i] <= '0;
        end else begin
            p16[0] <= {1'b0, add_a16} + {1'b0, add_b16} + {4'd0, add_cin16};
            for (int i = 1; i < LAT16; i++) p16[i] <= p16[i-1];
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT8; i++) p8[i] <= '0;
        end else begin
            p8[0] <= {1'b0, add_a8} + {1'b0, add_b8} + {4'd0, add_cin8};
            for (int i = 1; i < LAT8; i++) p8[i] <= p8[i-1];
        end
    end

    assign {add_cout16, add_sum16} = p16[LAT16-1];
    assign {add_cout8,  add_sum8}  = p8[LAT8-1];

    logic [16:0] q16 [$];
    logic [8:0]  q8  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the 16-bit instance: latency, hold stability and scoreboard pops.
    bit          w16 = 0, pv16 = 0, ph16 = 0;
    int          acc16 = 0;
    logic [16:0] ps16 = '0;
    always @(negedge clk) begin
        if (!reset) begin
            w16 = 0; pv16 = 0; ph16 = 0;
        end else begin
            if (pv16 && !ph16) begin
                check("hold_valid16", {31'd0, out_valid16}, 32'd1);
                check("hold_result16", {15'd0, out_cout16, out_sum16}, {15'd0, ps16});
            end
            if (out_valid16 && w16) begin
                check("latency16", cyc + 1 - acc16, EXP_LAT16);
                w16 = 0;
            end
            if (out_valid16 && out_ready16) begin
                check("pending16", {31'd0, q16.size() != 0}, 32'd1);
                if (q16.size() != 0)
                    check("result16", {15'd0, out_cout16, out_sum16}, {15'd0, q16.pop_front()});
            end
            if (in_valid16 && in_ready16) begin
                w16 = 1; acc16 = cyc + 1;
            end
            pv16 = out_valid16;
            ph16 = out_valid16 && out_ready16;
            ps16 = {out_cout16, out_sum16};
        end
    end

    // Monitor for the 8-bit instance.
    bit         w8 = 0, pv8 = 0, ph8 = 0;
    int         acc8 = 0;
    logic [8:0] ps8 = '0;
    always @(negedge clk) begin
        if (!reset) begin
            w8 = 0; pv8 = 0; ph8 = 0;
        end else begin
            if (pv8 && !ph8) begin
                check("hold_valid8", {31'd0, out_valid8}, 32'd1);
                check("hold_result8", {23'd0, out_cout8, out_sum8}, {23'd0, ps8});
            end
            if (out_valid8 && w8) begin
                check("latency8", cyc + 1 - acc8, EXP_LAT8);
                w8 = 0;
            end
            if (out_valid8 && out_ready8) begin
                check("pending8", {31'd0, q8.size() != 0}, 32'd1);
                if (q8.size() != 0)
                    check("result8", {23'd0, out_cout8, out_sum8}, {23'd0, q8.pop_front()});
            end
            if (in_valid8 && in_ready8) begin
                w8 = 1; acc8 = cyc + 1;
            end
            pv8 = out_valid8;
            ph8 = out_valid8 && out_ready8;
            ps8 = {out_cout8, out_sum8};
        end
    end

    // Drives one request into the 16-bit instance; returns just after the accept edge.
    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        bit acc = 0;
        @(posedge clk); #1;
        in_valid16 = 1'b1; in_a16 = a; in_b16 = b; in_cin16 = cin;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            if (in_ready16) acc = 1;
            else begin @(posedge clk); #1; end
        end
        check("accept16", {31'd0, acc}, 32'd1);
        if (acc) q16.push_back({1'b0, a} + {1'b0, b} + {16'd0, cin});
        @(posedge clk); #1;
        in_valid16 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        bit acc = 0;
        @(posedge clk); #1;
        in_valid8 = 1'b1; in_a8 = a; in_b8 = b; in_cin8 = cin;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            if (in_ready8) acc = 1;
            else begin @(posedge clk); #1; end
        end
        check("accept8", {31'd0, acc}, 32'd1);
        if (acc) q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic drain16();
        for (int t = 0; t < 200 && q16.size() != 0; t++) @(negedge clk);
        check("drain16", q16.size(), 32'd0);
    endtask

    task automatic check_idle16(input string tag);
        check({tag, "_out_sum"},   {16'd0, out_sum16},   32'd0);
        check({tag, "_out_cout"},  {31'd0, out_cout16},  32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid16}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy16},      32'd0);
        check({tag, "_add_a"},     {28'd0, add_a16},     32'd0);
        check({tag, "_add_b"},     {28'd0, add_b16},     32'd0);
        check({tag, "_add_cin"},   {31'd0, add_cin16},   32'd0);
        check({tag, "_in_ready"},  {31'd0, in_ready16},  32'd1);
    endtask

    bit done8 = 0;

    initial begin
        // Reset state
        #12;
        check_idle16("reset");
        check("reset_in_ready8", {31'd0, in_ready8}, 32'd1);
        @(negedge clk);
        reset = 1'b1;

        // Directed operations (scoreboard checks sum, carry and latency)
        start16(16'h1234, 16'h4321, 1'b0);
        drain16();
        start16(16'hFFFF, 16'h0000, 1'b1);
        drain16();
        start16(16'hFFFF, 16'hFFFF, 1'b1);
        drain16();
        start16(16'h0F0F, 16'h00F1, 1'b0);
        drain16();

        // Back-pressure: result held while out_ready is low, new request refused
        out_ready16 = 1'b0;
        start16(16'hABCD, 16'h1111, 1'b1);
        for (int t = 0; t < 50 && !out_valid16; t++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid16 = 1'b1; in_a16 = 16'h1111; in_b16 = 16'h1111; in_cin16 = 1'b0;
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid16}, 32'd1);
            check("bp_in_ready",  {31'd0, in_ready16},  32'd0);
            check("bp_result",    {15'd0, out_cout16, out_sum16}, {15'd0, 17'h0BCDF});
        end
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        out_ready16 = 1'b1;
        drain16();
        repeat (20) @(negedge clk);
        check("bp_not_accepted_busy",  {31'd0, busy16},      32'd0);
        check("bp_not_accepted_valid", {31'd0, out_valid16}, 32'd0);

        // Reset during WAIT of nibble 2, then a clean operation
        start16(16'h1234, 16'h5678, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("mid_busy",     {31'd0, busy16},     32'd1);
        check("mid_in_ready", {31'd0, in_ready16}, 32'd0);
        reset = 1'b0;
        #1;
        check_idle16("midrst");
        q16.delete();
        @(negedge clk);
        reset = 1'b1;
        start16(16'h0001, 16'h0001, 1'b0);
        drain16();

        // Randomised 8-bit traffic with gaps and random back-pressure
        fork
            begin
                for (int n = 0; n < 500; n++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send8(8'($urandom), 8'($urandom), 1'($urandom));
                end
                done8 = 1;
            end
            begin
                while (!done8) begin
                    @(posedge clk); #1;
                    out_ready8 = 1'($urandom);
                end
            end
        join
        out_ready8 = 1'b1;
        for (int t = 0; t < 200 && q8.size() != 0; t++) @(negedge clk);
        check("drain8", q8.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
